// File: rtl/jiajian.sv
// Registered add/subtract/absolute-difference unit over two unsigned W-bit operands.
// One operation per clock; result, sign and zero flags appear one cycle after in_valid.
module jiajian #(
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   sl,
    output logic [W:0]   c,
    output logic         out_valid,
    output logic         neg,
    output logic         zero
);

    localparam int unsigned CW = W + 1;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AMB = 2'b01;
    localparam logic [1:0] OP_BMA = 2'b10;
    localparam logic [1:0] OP_ABS = 2'b11;

    logic [CW-1:0] a_ext;
    logic [CW-1:0] b_ext;
    logic [CW-1:0] diff_ab;
    logic [CW-1:0] diff_ba;
    logic [CW-1:0] c_d;
    logic          neg_d;

    logic [CW-1:0] c_q;
    logic          out_valid_q;
    logic          neg_q;
    logic          zero_q;

    // Operands are zero-extended one bit so every mode fits in W+1 bits without overflow.
    always_comb begin
        a_ext   = CW'(a);
        b_ext   = CW'(b);
        diff_ab = a_ext - b_ext;
        diff_ba = b_ext - a_ext;
        c_d     = '0;
        neg_d   = 1'b0;
        case (sl)
            OP_ADD: c_d = a_ext + b_ext;
            OP_AMB: begin
                c_d   = diff_ab;
                neg_d = diff_ab[W];
            end
            OP_BMA: begin
                c_d   = diff_ba;
                neg_d = diff_ba[W];
            end
            OP_ABS: c_d = diff_ab[W] ? diff_ba : diff_ab;
            default: c_d = '0;
        endcase
    end

    // Results and flags hold while idle; only out_valid tracks in_valid every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q         <= '0;
            out_valid_q <= 1'b0;
            neg_q       <= 1'b0;
            zero_q      <= 1'b1;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                c_q    <= c_d;
                neg_q  <= neg_d;
                zero_q <= (c_d == '0);
            end
        end
    end

    assign c         = c_q;
    assign out_valid = out_valid_q;
    assign neg       = neg_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_jiajian.sv
// Directed-vector bench for jiajian (W=6): each task drives one scenario and
// compares {out_valid, neg, zero, c} against hand-computed values.
module tb_jiajian;

    localparam int unsigned W = 6;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   sl;
    logic [W:0]   c;
    logic         out_valid;
    logic         neg;
    logic         zero;

    int errors;
    int checks;

    jiajian #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sl        (sl),
        .c         (c),
        .out_valid (out_valid),
        .neg       (neg),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
    task automatic step(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [1:0] vsl, input logic vv);
        a        = va;
        b        = vb;
        sl       = vsl;
        in_valid = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sl       = 2'b00;
        #12;
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL reset_init: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/1/0",
                     out_valid, neg, zero, c);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_add;
        step(6'd4, 6'd10, 2'b00, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd14}) begin
            errors++;
            $display("FAIL add_4_10: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/14",
                     out_valid, neg, zero, c);
        end
        step(6'd63, 6'd63, 2'b00, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd126}) begin
            errors++;
            $display("FAIL add_63_63: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/126",
                     out_valid, neg, zero, c);
        end
        step(6'd0, 6'd0, 2'b00, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL add_0_0: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/1/0",
                     out_valid, neg, zero, c);
        end
    endtask

    task automatic test_sub;
        step(6'd4, 6'd10, 2'b01, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b1, 1'b0, 7'b1111010}) begin
            errors++;
            $display("FAIL sub_a_minus_b: ov/neg/zero/c=%b/%b/%b/%b expected 1/1/0/1111010",
                     out_valid, neg, zero, c);
        end
        step(6'd4, 6'd10, 2'b10, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd6}) begin
            errors++;
            $display("FAIL sub_b_minus_a: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/6",
                     out_valid, neg, zero, c);
        end
        step(6'd0, 6'd63, 2'b01, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b1, 1'b0, 7'b1000001}) begin
            errors++;
            $display("FAIL sub_min: ov/neg/zero/c=%b/%b/%b/%b expected 1/1/0/1000001",
                     out_valid, neg, zero, c);
        end
        step(6'd63, 6'd0, 2'b01, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd63}) begin
            errors++;
            $display("FAIL sub_max: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/63",
                     out_valid, neg, zero, c);
        end
        step(6'd20, 6'd5, 2'b10, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b1, 1'b0, 7'b1110001}) begin
            errors++;
            $display("FAIL sub_b_minus_a_neg: ov/neg/zero/c=%b/%b/%b/%b expected 1/1/0/1110001",
                     out_valid, neg, zero, c);
        end
        step(6'd17, 6'd17, 2'b10, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL sub_equal: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/1/0",
                     out_valid, neg, zero, c);
        end
    endtask

    task automatic test_abs;
        step(6'd9, 6'd9, 2'b11, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL abs_equal: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/1/0",
                     out_valid, neg, zero, c);
        end
        step(6'd3, 6'd40, 2'b11, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd37}) begin
            errors++;
            $display("FAIL abs_a_lt_b: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/37",
                     out_valid, neg, zero, c);
        end
        step(6'd40, 6'd3, 2'b11, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd37}) begin
            errors++;
            $display("FAIL abs_a_gt_b: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/37",
                     out_valid, neg, zero, c);
        end
        step(6'd0, 6'd63, 2'b11, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd63}) begin
            errors++;
            $display("FAIL abs_extreme: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/63",
                     out_valid, neg, zero, c);
        end
    endtask

    task automatic test_back_to_back;
        step(6'd1, 6'd2, 2'b00, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd3}) begin
            errors++;
            $display("FAIL stream_0: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/3",
                     out_valid, neg, zero, c);
        end
        step(6'd1, 6'd2, 2'b01, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b1, 1'b0, 7'b1111111}) begin
            errors++;
            $display("FAIL stream_1: ov/neg/zero/c=%b/%b/%b/%b expected 1/1/0/1111111",
                     out_valid, neg, zero, c);
        end
        step(6'd50, 6'd8, 2'b11, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b0, 1'b0, 7'd42}) begin
            errors++;
            $display("FAIL stream_2: ov/neg/zero/c=%b/%b/%b/%0d expected 1/0/0/42",
                     out_valid, neg, zero, c);
        end
        // Idle cycles with changing operands must not disturb the held result.
        step(6'd7, 6'd7, 2'b11, 1'b0);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b0, 7'd42}) begin
            errors++;
            $display("FAIL hold_0: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/0/42",
                     out_valid, neg, zero, c);
        end
        step(6'd0, 6'd9, 2'b01, 1'b0);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b0, 7'd42}) begin
            errors++;
            $display("FAIL hold_1: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/0/42",
                     out_valid, neg, zero, c);
        end
        step(6'd0, 6'd5, 2'b01, 1'b1);
        step(6'd0, 6'd0, 2'b00, 1'b0);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b1, 1'b0, 7'b1111011}) begin
            errors++;
            $display("FAIL hold_neg: ov/neg/zero/c=%b/%b/%b/%b expected 0/1/0/1111011",
                     out_valid, neg, zero, c);
        end
    endtask

    task automatic test_reset_mid_op;
        step(6'd4, 6'd10, 2'b00, 1'b1);
        a        = 6'd5;
        b        = 6'd9;
        sl       = 2'b01;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL reset_async: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/1/0",
                     out_valid, neg, zero, c);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL reset_discard: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/1/0",
                     out_valid, neg, zero, c);
        end
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        step(6'd5, 6'd9, 2'b01, 1'b0);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b0, 1'b0, 1'b1, 7'd0}) begin
            errors++;
            $display("FAIL reset_release_idle: ov/neg/zero/c=%b/%b/%b/%0d expected 0/0/1/0",
                     out_valid, neg, zero, c);
        end
        step(6'd30, 6'd12, 2'b10, 1'b1);
        checks++;
        if ({out_valid, neg, zero, c} !== {1'b1, 1'b1, 1'b0, 7'b1101110}) begin
            errors++;
            $display("FAIL first_after_reset: ov/neg/zero/c=%b/%b/%b/%b expected 1/1/0/1101110",
                     out_valid, neg, zero, c);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_add();
        test_sub();
        test_abs();
        test_back_to_back();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
